uart_buf_rd_sched: RTL and testbench
====================================

// Module: uart_buf_rd_sched
// PURPOSE
//  Round-robin read scheduler for the per-channel UART receive buffers (ramUART, 5 x 32x8).
//  Collects "buffer full" pulses from the per-channel write-address counters and grants one
//  channel at a time. For the granted channel it drives a burst of BYTES sequential read
//  addresses with a one-hot read enable. Those reads feed the OrbPacker/SlowPacker stage.
//  Flags overruns and honours a downstream hold during orbit-buffer switching.
// PARAMETERS
//  NCH    5   number of UART channels (1..8)
//  AW     5   buffer address width
//  BYTES  24  bytes read per burst (2..2**AW)
//  GAP    2   idle cycles after each burst before the next grant (0..15)
// PORTS
//  clk      in   1       system clock (80 MHz domain)
//  rst      in   1       asynchronous, active-low reset
//  iDone    in   NCH     per-channel single-cycle pulse: channel buffer holds a complete packet
//  iHold    in   1       downstream stall; freezes the burst while high
//  iClrOvf  in   1       single-cycle pulse: clears all oOvf bits
//  oRdEn    out  NCH     one-hot read enable to channel buffers
//  oRdAdr   out  AW      read address, shared by all buffers
//  oChan    out  3       index of granted channel (valid while oBusy)
//  oFirst   out  1       high with the oRdEn cycle at address 0
//  oLast    out  1       high with the oRdEn cycle at address BYTES-1
//  oBusy    out  1       high from grant until end of GAP
//  oPend    out  NCH     pending-request register (observability)
//  oOvf     out  NCH     sticky overrun: iDone[i] arrived while oPend[i] already set
// BEHAVIOUR
//  Reset (async, rst=0): every output and register is 0, FSM=IDLE, RR pointer=0.
//    Asserting rst mid-burst aborts immediately. No partial state survives.
//  Pending: iDone[i] sets oPend[i] on the next edge.
//    oPend[i] clears on the edge that enters READ for channel i.
//    If iDone[i] and the grant of i fall on the same edge, set wins: oPend[i] stays 1, no overrun.
//  Overrun: iDone[i] while oPend[i]=1 (and not granted that edge) sets oOvf[i].
//    oOvf holds until iClrOvf. If iClrOvf and a new overrun coincide, set wins.
//  FSM:
//    IDLE: |oPend -> SEL.
//    SEL (1 cycle): winner = first set oPend bit at or after the RR pointer, searched upward
//      modulo NCH. Latch oChan. RR pointer <= winner+1 (wraps NCH-1 -> 0). -> READ.
//    READ: each cycle with iHold=0 drives oRdEn[oChan]=1 at oRdAdr=cnt, then cnt++.
//      With iHold=1: oRdEn=0, oRdAdr and cnt frozen.
//      After the address BYTES-1 is issued: GAP>0 -> GAPW, else |oPend ? SEL : IDLE.
//    GAPW: count GAP cycles with oRdEn=0, then |oPend ? SEL : IDLE.
//  Latency: iDone at edge t with FSM idle -> oPend at t+1 -> SEL at t+2 -> first oRdEn at t+3.
//  Burst length is exactly BYTES enable cycles, excluding hold cycles.
//  oRdAdr is 0 outside READ. Buffer q is valid the cycle after oRdEn; consumers align to that.
//  oBusy = (state==SEL|READ|GAPW). oFirst/oLast are only asserted together with oRdEn.
//  Width rules: cnt is AW bits and never wraps, because BYTES<=2**AW.
//    oChan is zero-extended to 3 bits.
//  All outputs are registered.
// TESTING
//  1 Single request: iDone=5'b00100 pulse -> 3 cycles later oRdEn=5'b00100,
//    oRdAdr 0..23 on consecutive cycles, oFirst@0, oLast@23, then 2 idle cycles, oBusy=0.
//  2 Fairness: iDone=5'b11111 in one cycle -> bursts in channel order 0,1,2,3,4, each 24 reads.
//    Then iDone=5'b00011 -> order 0,1.
//  3 Hold: assert iHold for 5 cycles at oRdAdr=10 -> oRdEn=0 and oRdAdr=10 held.
//    The burst resumes at address 10, the total enable count is still 24, and oLast arrives 5 cycles late.
//  4 Overrun: iDone[3] twice while channel 1 is being read -> oOvf=5'b01000 and one burst for channel 3.
//    iClrOvf -> oOvf=0.
//    Same-edge grant+iDone on channel 2 -> oPend[2] stays 1, oOvf[2]=0.
//  5 Async reset at oRdAdr=12 -> all outputs 0 immediately without a clock edge.
//    After release, a fresh iDone[4] gives a burst starting at address 0.
//  6 GAP=0 build: back-to-back requests -> next burst's SEL immediately follows oLast,
//    with exactly one dead cycle between bursts.

Source files
------------

// File: rtl/uart_buf_rd_sched.sv
// Round-robin read scheduler for the per-channel UART receive buffers.
// Grants one pending channel at a time and issues a burst of BYTES sequential reads to it.
module uart_buf_rd_sched #(
  parameter int NCH   = 5,
  parameter int AW    = 5,
  parameter int BYTES = 24,
  parameter int GAP   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] iDone,
  input  logic           iHold,
  input  logic           iClrOvf,
  output logic [NCH-1:0] oRdEn,
  output logic [AW-1:0]  oRdAdr,
  output logic [2:0]     oChan,
  output logic           oFirst,
  output logic           oLast,
  output logic           oBusy,
  output logic [NCH-1:0] oPend,
  output logic [NCH-1:0] oOvf
);

  typedef enum logic [1:0] {IDLE, SEL, READ, GAPW} state_t;

  localparam logic [AW-1:0] LAST_ADR = AW'(BYTES - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t          state;
  logic [2:0]      rr;
  logic [AW-1:0]   cnt;
  logic [3:0]      gcnt;
  logic [2:0]      win;
  logic [2:0]      win_hi;
  logic [2:0]      win_lo;
  logic            found_hi;
  logic [NCH-1:0]  gnt;

  // Winner is the lowest pending index at or above rr; if none, the lowest pending index overall.
  // NOTE: every variable assigned in always_comb gets a default up front, so no path can infer a latch.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (oPend[i]) begin
        win_lo = 3'(i);
        if (i >= int'(rr)) begin
          win_hi   = 3'(i);
          found_hi = 1'b1;
        end
      end
    end
    win = found_hi ? win_hi : win_lo;
  end

  // Grant happens on the SEL->READ edge; the granted bit is cleared unless a new iDone sets it again.
  assign gnt = (state == SEL) ? (NCH'(1) << win) : '0;

  // NOTE: all state here is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr     <= '0;
      cnt    <= '0;
      gcnt   <= '0;
      oRdEn  <= '0;
      oRdAdr <= '0;
      oChan  <= '0;
      oFirst <= 1'b0;
      oLast  <= 1'b0;
      oBusy  <= 1'b0;
      oPend  <= '0;
      oOvf   <= '0;
    end else begin
      oPend <= (oPend & ~gnt) | iDone;
      oOvf  <= (iClrOvf ? '0 : oOvf) | (iDone & oPend & ~gnt);

      case (state)
        IDLE: begin
          if (|oPend) begin
            state <= SEL;
            oBusy <= 1'b1;
          end
        end

        SEL: begin
          oChan <= win;
          rr    <= (win == 3'(NCH - 1)) ? 3'd0 : win + 3'd1;
          state <= READ;
          if (!iHold) begin
            oRdEn  <= NCH'(1) << win;
            oRdAdr <= '0;
            oFirst <= 1'b1;
            cnt    <= AW'(1);
          end else begin
            cnt    <= '0;
          end
        end

        READ: begin
          if (oLast) begin
            oRdEn  <= '0;
            oRdAdr <= '0;
            oFirst <= 1'b0;
            oLast  <= 1'b0;
            gcnt   <= '0;
            if (GAP > 0) begin
              state <= GAPW;
            end else begin
              state <= (|oPend) ? SEL : IDLE;
              oBusy <= |oPend;
            end
          end else if (!iHold) begin
            oRdEn  <= NCH'(1) << oChan;
            oRdAdr <= cnt;
            oFirst <= (cnt == '0);
            oLast  <= (cnt == LAST_ADR);
            cnt    <= (cnt == LAST_ADR) ? '0 : cnt + AW'(1);
          end else begin
            // Stalled: show the next address to be issued with the enable dropped.
            oRdEn  <= '0;
            oRdAdr <= cnt;
            oFirst <= 1'b0;
            oLast  <= 1'b0;
          end
        end

        GAPW: begin
          if (gcnt == GAP_LAST) begin
            state <= (|oPend) ? SEL : IDLE;
            oBusy <= |oPend;
          end else begin
            gcnt <= gcnt + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_buf_rd_sched.sv
// Self-checking bench for uart_buf_rd_sched: a scoreboard of expected read cycles plus
// per-scenario timing checks on a GAP=2 instance and a GAP=0 instance.
module tb_uart_buf_rd_sched;

  localparam int NCH   = 5;
  localparam int AW    = 5;
  localparam int BYTES = 24;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] iDone, done2;
  logic           iHold, iClrOvf;
  logic [NCH-1:0] oRdEn, oPend, oOvf;
  logic [AW-1:0]  oRdAdr;
  logic [2:0]     oChan;
  logic           oFirst, oLast, oBusy;

  logic [NCH-1:0] rd_en2, pend2, ovf2;
  logic [AW-1:0]  rd_adr2;
  logic [2:0]     chan2;
  logic           first2, last2, busy2;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct packed {
    logic [2:0]    chan;
    logic [AW-1:0] adr;
    logic          first;
    logic          last;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [NCH-1:0] exp_en;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_buf_rd_sched #(.NCH(NCH), .AW(AW), .BYTES(BYTES), .GAP(2)) dut (
    .clk(clk), .rst(rst), .iDone(iDone), .iHold(iHold), .iClrOvf(iClrOvf),
    .oRdEn(oRdEn), .oRdAdr(oRdAdr), .oChan(oChan), .oFirst(oFirst), .oLast(oLast),
    .oBusy(oBusy), .oPend(oPend), .oOvf(oOvf)
  );

  uart_buf_rd_sched #(.NCH(NCH), .AW(AW), .BYTES(BYTES), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .iDone(done2), .iHold(1'b0), .iClrOvf(1'b0),
    .oRdEn(rd_en2), .oRdAdr(rd_adr2), .oChan(chan2), .oFirst(first2), .oLast(last2),
    .oBusy(busy2), .oPend(pend2), .oOvf(ovf2)
  );

  // Scoreboard: every enabled read cycle of the GAP=2 instance must match the next expected entry.
  always @(negedge clk) begin
    if (rst && oRdEn != '0) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected: got en=%b adr=%0d, no read expected", oRdEn, oRdAdr);
      end else begin
        e      = sb.pop_front();
        exp_en = NCH'(1) << e.chan;
        if ({oRdEn, oChan, oRdAdr, oFirst, oLast} !== {exp_en, e.chan, e.adr, e.first, e.last}) begin
          mismatched++;
          $display("FAIL sb_read: got en=%b ch=%0d adr=%0d f=%b l=%b, want en=%b ch=%0d adr=%0d f=%b l=%b",
                   oRdEn, oChan, oRdAdr, oFirst, oLast, exp_en, e.chan, e.adr, e.first, e.last);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic push_burst(input int ch);
    exp_t x;
    for (int a = 0; a < BYTES; a++) begin
      x.chan  = 3'(ch);
      x.adr   = AW'(a);
      x.first = (a == 0);
      x.last  = (a == BYTES - 1);
      sb.push_back(x);
    end
  endtask

  // Called right after a negedge; returns on the next negedge with the request already registered.
  task automatic pulse_done(input logic [NCH-1:0] v);
    iDone = v;
    @(negedge clk);
    iDone = '0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !oBusy) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_adr(input int adr, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (oRdEn != '0 && oRdAdr == AW'(adr)) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    compared++;
    if ({oRdEn, oRdAdr, oChan, oFirst, oLast, oBusy, oPend, oOvf, rd_en2, busy2, pend2} !== '0) begin
      mismatched++;
      $display("FAIL reset_hold: outputs %h, want 0",
               {oRdEn, oRdAdr, oChan, oFirst, oLast, oBusy, oPend, oOvf});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({oRdEn, oRdAdr, oChan, oFirst, oLast, oBusy, oPend, oOvf} !== '0) begin
      mismatched++;
      $display("FAIL reset_release: outputs %h, want 0",
               {oRdEn, oRdAdr, oChan, oFirst, oLast, oBusy, oPend, oOvf});
    end
  endtask

  task automatic test_fairness;
    for (int c = 0; c < NCH; c++) push_burst(c);
    pulse_done(5'b11111);
    compared++;
    if (oPend !== 5'b11111) begin
      mismatched++;
      $display("FAIL fair_pend: got %b want 11111", oPend);
    end
    wait_drain(1000);
    compared++;
    if (sb.size() != 0 || oBusy) begin
      mismatched++;
      $display("FAIL fair_drain5: left=%0d busy=%b want 0/0", sb.size(), oBusy);
    end
    push_burst(0);
    push_burst(1);
    pulse_done(5'b00011);
    wait_drain(400);
    compared++;
    if (sb.size() != 0 || oBusy) begin
      mismatched++;
      $display("FAIL fair_drain2: left=%0d busy=%b want 0/0", sb.size(), oBusy);
    end
  endtask

  task automatic test_single;
    push_burst(2);
    pulse_done(5'b00100);
    compared++;
    if (oPend !== 5'b00100 || oRdEn !== '0) begin
      mismatched++;
      $display("FAIL single_pend: pend=%b en=%b want 00100/00000", oPend, oRdEn);
    end
    @(negedge clk);
    compared++;
    if (oBusy !== 1'b1 || oRdEn !== '0) begin
      mismatched++;
      $display("FAIL single_sel: busy=%b en=%b want 1/00000", oBusy, oRdEn);
    end
    @(negedge clk);
    compared++;
    if (oRdEn !== 5'b00100 || oFirst !== 1'b1 || oPend !== '0) begin
      mismatched++;
      $display("FAIL single_latency: en=%b first=%b pend=%b want 00100/1/00000", oRdEn, oFirst, oPend);
    end
    for (int i = 0; i < 100; i++) begin
      if (oLast) break;
      @(negedge clk);
    end
    compared++;
    if (oLast !== 1'b1) begin
      mismatched++;
      $display("FAIL single_last_timeout: last=%b want 1", oLast);
    end
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      compared++;
      if (oBusy !== 1'b1 || oRdEn !== '0 || oRdAdr !== '0) begin
        mismatched++;
        $display("FAIL single_gap%0d: busy=%b en=%b adr=%0d want 1/00000/0", g, oBusy, oRdEn, oRdAdr);
      end
    end
    @(negedge clk);
    compared++;
    if (oBusy !== 1'b0) begin
      mismatched++;
      $display("FAIL single_idle: busy=%b want 0", oBusy);
    end
    wait_drain(50);
  endtask

  task automatic test_hold;
    int t_first = 0;
    int t_last  = 0;
    push_burst(0);
    pulse_done(5'b00001);
    for (int i = 0; i < 50; i++) begin
      if (oFirst) t_first = cyc;
      if (oRdEn != '0 && oRdAdr == AW'(9)) break;
      @(negedge clk);
    end
    compared++;
    if (oRdEn !== 5'b00001 || oRdAdr !== AW'(9)) begin
      mismatched++;
      $display("FAIL hold_reach9: en=%b adr=%0d want 00001/9", oRdEn, oRdAdr);
    end
    iHold = 1'b1;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      compared++;
      if (oRdEn !== '0 || oRdAdr !== AW'(10) || oBusy !== 1'b1) begin
        mismatched++;
        $display("FAIL hold_freeze%0d: en=%b adr=%0d busy=%b want 00000/10/1", h, oRdEn, oRdAdr, oBusy);
      end
    end
    iHold = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (oLast) begin
        t_last = cyc;
        break;
      end
    end
    compared++;
    if (t_last - t_first != BYTES - 1 + 5) begin
      mismatched++;
      $display("FAIL hold_last_delay: got %0d cycles first->last want %0d", t_last - t_first, BYTES - 1 + 5);
    end
    wait_drain(50);
  endtask

  task automatic test_overrun;
    push_burst(1);
    push_burst(3);
    pulse_done(5'b00010);
    wait_adr(3, 50);
    pulse_done(5'b01000);
    repeat (2) @(negedge clk);
    pulse_done(5'b01000);
    compared++;
    if (oOvf !== 5'b01000 || oPend !== 5'b01000) begin
      mismatched++;
      $display("FAIL ovf_set: ovf=%b pend=%b want 01000/01000", oOvf, oPend);
    end
    wait_drain(200);
    compared++;
    if (oOvf !== 5'b01000 || sb.size() != 0) begin
      mismatched++;
      $display("FAIL ovf_sticky: ovf=%b left=%0d want 01000/0", oOvf, sb.size());
    end
    iClrOvf = 1'b1;
    @(negedge clk);
    iClrOvf = 1'b0;
    compared++;
    if (oOvf !== '0) begin
      mismatched++;
      $display("FAIL ovf_clear: ovf=%b want 00000", oOvf);
    end
    // Re-request channel 2 exactly on its grant edge: the request must survive without an overrun.
    push_burst(2);
    push_burst(2);
    pulse_done(5'b00100);
    @(negedge clk);
    compared++;
    if (oBusy !== 1'b1 || oRdEn !== '0) begin
      mismatched++;
      $display("FAIL same_edge_sel: busy=%b en=%b want 1/00000", oBusy, oRdEn);
    end
    pulse_done(5'b00100);
    compared++;
    if (oPend !== 5'b00100 || oOvf !== '0) begin
      mismatched++;
      $display("FAIL same_edge_set: pend=%b ovf=%b want 00100/00000", oPend, oOvf);
    end
    wait_drain(300);
    compared++;
    if (sb.size() != 0 || oBusy || oPend !== '0) begin
      mismatched++;
      $display("FAIL same_edge_drain: left=%0d busy=%b pend=%b want 0/0/00000", sb.size(), oBusy, oPend);
    end
  endtask

  task automatic test_async_reset;
    push_burst(4);
    pulse_done(5'b10000);
    wait_adr(12, 50);
    compared++;
    if (oRdEn !== 5'b10000 || oRdAdr !== AW'(12)) begin
      mismatched++;
      $display("FAIL arst_reach12: en=%b adr=%0d want 10000/12", oRdEn, oRdAdr);
    end
    #2 rst = 1'b0;
    #1;
    compared++;
    if ({oRdEn, oRdAdr, oChan, oFirst, oLast, oBusy, oPend, oOvf} !== '0) begin
      mismatched++;
      $display("FAIL arst_clear: outputs %h want 0",
               {oRdEn, oRdAdr, oChan, oFirst, oLast, oBusy, oPend, oOvf});
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_burst(4);
    pulse_done(5'b10000);
    wait_drain(100);
    compared++;
    if (sb.size() != 0 || oBusy) begin
      mismatched++;
      $display("FAIL arst_fresh_burst: left=%0d busy=%b want 0/0", sb.size(), oBusy);
    end
  endtask

  task automatic test_back_to_back;
    done2 = 5'b00011;
    @(negedge clk);
    done2 = '0;
    for (int i = 0; i < 100; i++) begin
      if (last2) break;
      @(negedge clk);
    end
    compared++;
    if (last2 !== 1'b1 || rd_en2 !== 5'b00001) begin
      mismatched++;
      $display("FAIL b2b_last0: last=%b en=%b want 1/00001", last2, rd_en2);
    end
    @(negedge clk);
    compared++;
    if (rd_en2 !== '0 || busy2 !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_dead: en=%b busy=%b want 00000/1", rd_en2, busy2);
    end
    @(negedge clk);
    compared++;
    if (rd_en2 !== 5'b00010 || first2 !== 1'b1 || rd_adr2 !== '0) begin
      mismatched++;
      $display("FAIL b2b_first1: en=%b first=%b adr=%0d want 00010/1/0", rd_en2, first2, rd_adr2);
    end
    for (int i = 0; i < 100; i++) begin
      if (!busy2) break;
      @(negedge clk);
    end
    compared++;
    if (busy2 !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_idle: busy=%b want 0", busy2);
    end
  endtask

  initial begin
    rst     = 1'b0;
    iDone   = '0;
    done2   = '0;
    iHold   = 1'b0;
    iClrOvf = 1'b0;
    test_reset();
    test_fairness();
    test_single();
    test_hold();
    test_overrun();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
